// File: rtl/sao_lcu_feeder_if.sv
// Bundle between the LCU feeder, the image and parameter memories and the
// SAO stage. The feeder drives the master side.
interface sao_lcu_feeder_if #(
  parameter int AW = 14,
  parameter int PW = 6
);
  logic          start;
  logic [1:0]    cfg_lcu_size;
  logic          busy;
  logic          img_rd;
  logic [AW-1:0] img_addr;
  logic [7:0]    img_q;
  logic          par_rd;
  logic [PW-1:0] par_addr;
  logic [23:0]   par_q;
  logic          in_en;
  logic [7:0]    din;
  logic [1:0]    sao_type;
  logic [4:0]    sao_band_pos;
  logic          sao_eo_class;
  logic [15:0]   sao_offset;
  logic [2:0]    lcu_x;
  logic [2:0]    lcu_y;
  logic [1:0]    lcu_size;
  logic          done;

  modport master (
    input  start, cfg_lcu_size, busy, img_q, par_q,
    output img_rd, img_addr, par_rd, par_addr, in_en, din,
           sao_type, sao_band_pos, sao_eo_class, sao_offset,
           lcu_x, lcu_y, lcu_size, done
  );

  modport slave (
    output start, cfg_lcu_size, busy, img_q, par_q,
    input  img_rd, img_addr, par_rd, par_addr, in_en, din,
           sao_type, sao_band_pos, sao_eo_class, sao_offset,
           lcu_x, lcu_y, lcu_size, done
  );
endinterface

// File: rtl/sao_lcu_feeder.sv
// Streams a 128x128 frame to the SAO stage in LCU order (row-major inside
// each LCU) together with the per-LCU parameters, honouring busy through a
// 2-entry output buffer.
//
// state  | meaning
// IDLE   | waiting for start
// PAR_RD | parameter read for the current LCU
// PAR_LD | parameters and LCU position registered onto the outputs
// STREAM | pixel reads issued and drained through the buffer
// GAP    | two idle cycles, then next LCU or done
module sao_lcu_feeder (
  input  logic             clk,
  input  logic             reset,
  sao_lcu_feeder_if.master bus
);
  typedef enum logic [2:0] {IDLE, PAR_RD, PAR_LD, STREAM, GAP} state_t;

  state_t      state;
  logic [1:0]  lsz;
  logic [2:0]  lx, ly;
  logic        gap_ph;
  logic        done_r;
  logic [1:0]  sao_type_r;
  logic [4:0]  sao_band_r;
  logic        sao_eo_r;
  logic [15:0] sao_off_r;
  logic [2:0]  lcu_x_r, lcu_y_r;

  logic [5:0]  rd_row, rd_col;
  logic        rd_all;
  logic [11:0] acc_cnt;
  logic [7:0]  buf0, buf1;
  logic [1:0]  occ;
  logic        rd_pend;

  logic [5:0]  n_m1;
  logic [2:0]  lpr_m1;
  logic [11:0] last_acc;
  logic [13:0] addr_w;
  logic [5:0]  par_addr_w;
  logic        accept;
  logic        img_rd_w;
  logic [2:0]  fill;

  // Size-dependent geometry; N is a power of two so addresses are plain
  // concatenations of LCU index and in-LCU offset.
  always_comb begin
    n_m1       = 6'd15;
    lpr_m1     = 3'd7;
    last_acc   = 12'd255;
    addr_w     = {ly, rd_row[3:0], lx, rd_col[3:0]};
    par_addr_w = {ly, lx};
    case (lsz)
      2'd1: begin
        n_m1       = 6'd31;
        lpr_m1     = 3'd3;
        last_acc   = 12'd1023;
        addr_w     = {ly[1:0], rd_row[4:0], lx[1:0], rd_col[4:0]};
        par_addr_w = {2'b00, ly[1:0], lx[1:0]};
      end
      2'd2: begin
        n_m1       = 6'd63;
        lpr_m1     = 3'd1;
        last_acc   = 12'd4095;
        addr_w     = {ly[0], rd_row, lx[0], rd_col};
        par_addr_w = {4'b0000, ly[0], lx[0]};
      end
      default: ;
    endcase
  end

  // Accept and read-issue decisions; a read is allowed when the buffer
  // still has room after this cycle's accept and the in-flight read land.
  always_comb begin
    accept   = (occ != 2'd0) && !bus.busy;
    fill     = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, accept};
    img_rd_w = (state == STREAM) && !rd_all && (fill < 3'd2);
  end

  assign bus.in_en        = accept;
  assign bus.din          = buf0;
  assign bus.img_rd       = img_rd_w;
  assign bus.img_addr     = addr_w;
  assign bus.par_rd       = (state == PAR_RD);
  assign bus.par_addr     = par_addr_w;
  assign bus.sao_type     = sao_type_r;
  assign bus.sao_band_pos = sao_band_r;
  assign bus.sao_eo_class = sao_eo_r;
  assign bus.sao_offset   = sao_off_r;
  assign bus.lcu_x        = lcu_x_r;
  assign bus.lcu_y        = lcu_y_r;
  assign bus.lcu_size     = lsz;
  assign bus.done         = done_r;

  // Output buffer plus read/accept counters for the current LCU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      buf0    <= '0;
      buf1    <= '0;
      occ     <= '0;
      rd_row  <= '0;
      rd_col  <= '0;
      rd_all  <= 1'b0;
      acc_cnt <= '0;
    end else begin
      rd_pend <= img_rd_w;
      case ({rd_pend, accept})
        2'b10: begin
          if (occ == 2'd0) buf0 <= bus.img_q;
          else             buf1 <= bus.img_q;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= bus.img_q;
          end else begin
            buf0 <= buf1;
            buf1 <= bus.img_q;
          end
        end
        default: ;
      endcase
      if (state == PAR_LD) begin
        rd_row  <= '0;
        rd_col  <= '0;
        rd_all  <= 1'b0;
        acc_cnt <= '0;
      end else begin
        if (img_rd_w) begin
          if (rd_col == n_m1) begin
            rd_col <= '0;
            if (rd_row == n_m1) rd_all <= 1'b1;
            else                rd_row <= rd_row + 6'd1;
          end else begin
            rd_col <= rd_col + 6'd1;
          end
        end
        if (accept) acc_cnt <= acc_cnt + 12'd1;
      end
    end
  end

  // Frame sequencing FSM with registered parameter, position and done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lsz        <= '0;
      lx         <= '0;
      ly         <= '0;
      gap_ph     <= 1'b0;
      done_r     <= 1'b0;
      sao_type_r <= '0;
      sao_band_r <= '0;
      sao_eo_r   <= 1'b0;
      sao_off_r  <= '0;
      lcu_x_r    <= '0;
      lcu_y_r    <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            lsz   <= (bus.cfg_lcu_size == 2'd3) ? 2'd2 : bus.cfg_lcu_size;
            lx    <= '0;
            ly    <= '0;
            state <= PAR_RD;
          end
        end
        PAR_RD: state <= PAR_LD;
        PAR_LD: begin
          sao_type_r <= bus.par_q[23:22];
          sao_band_r <= bus.par_q[21:17];
          sao_eo_r   <= bus.par_q[16];
          sao_off_r  <= bus.par_q[15:0];
          lcu_x_r    <= lx;
          lcu_y_r    <= ly;
          state      <= STREAM;
        end
        STREAM: begin
          if (accept && (acc_cnt == last_acc)) begin
            gap_ph <= 1'b0;
            state  <= GAP;
          end
        end
        GAP: begin
          if (!gap_ph) begin
            gap_ph <= 1'b1;
          end else if ((lx == lpr_m1) && (ly == lpr_m1)) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end else begin
            if (lx == lpr_m1) begin
              lx <= '0;
              ly <= ly + 3'd1;
            end else begin
              lx <= lx + 3'd1;
            end
            state <= PAR_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sao_lcu_feeder.sv
// Self-checking bench for sao_lcu_feeder: memory models, busy generator, a
// reference model of the LCU-order pixel stream and a per-cycle checker.
module tb_sao_lcu_feeder;
  logic clk = 1'b0;
  logic reset;
  sao_lcu_feeder_if bus ();

  sao_lcu_feeder dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]  mem  [16384];
  logic [23:0] pmem [64];
  int rd_cnt [16384];
  int din_log [17];
  int par_log [$];

  int n_tests = 0, n_fail = 0;
  int n = 16, exp_lsz = 0;
  int idx = 0, nreads = 0, done_cnt = 0, cyc = 0, last_cyc = 0;
  int busy_mode = 0, burst = 0, trig_idx = -1;
  int lcu1_addr = -1, first_rd_addr = -1;
  bit checking = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Address of the k-th pixel of the frame in LCU order.
  function automatic int golden_addr(input int nn, input int k);
    int lpr = 128 / nn;
    int lcu = k / (nn * nn);
    int p   = k % (nn * nn);
    return ((lcu / lpr) * nn + p / nn) * 128 + (lcu % lpr) * nn + p % nn;
  endfunction

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (bus.img_rd) bus.img_q <= mem[bus.img_addr];
    if (bus.par_rd) bus.par_q <= pmem[bus.par_addr];
  end

  // Back-pressure generator.
  always @(posedge clk) begin
    #1;
    case (busy_mode)
      1: begin
        if (burst > 0) begin
          bus.busy = 1'b1;
          burst--;
        end else if ((idx % 300 == 100) && (idx != trig_idx)) begin
          trig_idx = idx;
          bus.busy = 1'b1;
          burst    = 4;
        end else begin
          bus.busy = 1'b0;
        end
      end
      2: bus.busy = ($urandom_range(99) < 30);
      default: bus.busy = 1'b0;
    endcase
  end

  // Per-cycle comparison against the reference stream.
  always @(negedge clk) begin
    if (!reset && checking) begin
      int nn, lpr, lcu, ea;
      nn  = n * n;
      lpr = 128 / n;
      cyc++;
      if (bus.busy) chk("in_en_while_busy", int'(bus.in_en), 0);
      if (bus.img_rd) begin
        if (nreads == 0) first_rd_addr = int'(bus.img_addr);
        if (nreads == nn) lcu1_addr = int'(bus.img_addr);
        rd_cnt[bus.img_addr]++;
        nreads++;
      end
      if (bus.par_rd) par_log.push_back(int'(bus.par_addr));
      if (bus.in_en) begin
        lcu = idx / nn;
        ea  = golden_addr(n, idx);
        chk("din", int'(bus.din), int'(mem[ea]));
        chk("sao_params", int'({bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset}),
            int'(pmem[lcu]));
        chk("lcu_x", int'(bus.lcu_x), lcu % lpr);
        chk("lcu_y", int'(bus.lcu_y), lcu / lpr);
        chk("lcu_size", int'(bus.lcu_size), exp_lsz);
        if (busy_mode == 0 && idx > 0)
          chk("pixel_spacing", cyc - last_cyc, (idx % nn == 0) ? 7 : 1);
        if (idx < 17) din_log[idx] = int'(bus.din);
        last_cyc = cyc;
        idx++;
      end
      if (bus.done) begin
        done_cnt++;
        chk("done_pixel_count", idx, 16384);
        chk("done_latency", cyc - last_cyc, 3);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_en"}, int'(bus.in_en), 0);
    chk({tag, "_din"}, int'(bus.din), 0);
    chk({tag, "_img_rd"}, int'(bus.img_rd), 0);
    chk({tag, "_img_addr"}, int'(bus.img_addr), 0);
    chk({tag, "_par_rd"}, int'(bus.par_rd), 0);
    chk({tag, "_par_addr"}, int'(bus.par_addr), 0);
    chk({tag, "_params"}, int'({bus.sao_type, bus.sao_band_pos, bus.sao_eo_class, bus.sao_offset}), 0);
    chk({tag, "_lcu_pos"}, int'({bus.lcu_x, bus.lcu_y}), 0);
    chk({tag, "_lcu_size"}, int'(bus.lcu_size), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic begin_frame(input logic [1:0] cfg, input int mode);
    @(posedge clk);
    #1;
    n        = (cfg == 2'd0) ? 16 : (cfg == 2'd1) ? 32 : 64;
    exp_lsz  = (cfg == 2'd3) ? 2 : int'(cfg);
    idx      = 0;
    nreads   = 0;
    done_cnt = 0;
    cyc      = 0;
    last_cyc = 0;
    burst    = 0;
    trig_idx = -1;
    lcu1_addr     = -1;
    first_rd_addr = -1;
    par_log.delete();
    for (int a = 0; a < 16384; a++) rd_cnt[a] = 0;
    busy_mode = mode;
    checking  = 1;
    bus.cfg_lcu_size = cfg;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    for (int c = 0; c < 40000 && idx < target; c++) @(posedge clk);
    if (idx < target) chk("wait_pixels_timeout", idx, target);
  endtask

  task automatic finish_frame();
    int bad;
    for (int c = 0; c < 40000 && done_cnt == 0; c++) @(posedge clk);
    if (done_cnt == 0) chk("done_timeout", done_cnt, 1);
    repeat (10) @(posedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("read_total", nreads, 16384);
    bad = 0;
    for (int a = 0; a < 16384; a++) if (rd_cnt[a] != 1) bad++;
    chk("reads_not_once", bad, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cfg_lcu_size = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Size 16, ramp image, no back-pressure.
    for (int a = 0; a < 16384; a++) mem[a] = 8'(a);
    for (int p = 0; p < 64; p++) pmem[p] = 24'($urandom);
    begin_frame(2'd0, 0);
    finish_frame();
    for (int i = 0; i < 17; i++) chk("ramp_din", din_log[i], (i < 16) ? i : 128);

    // Size code 3 (acts as 64), index parameters, ignored mid-frame start.
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom_range(255));
    for (int p = 0; p < 64; p++) pmem[p] = {2'(p), 5'(p), 1'(p), 16'(p * 257 + 1)};
    begin_frame(2'd3, 0);
    wait_idx(1000);
    @(posedge clk);
    #1;
    bus.cfg_lcu_size = 2'd0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.cfg_lcu_size = 2'd3;
    finish_frame();
    for (int i = 0; i < 4; i++) chk("par_addr_seq", (par_log.size() > i) ? par_log[i] : -1, i);
    chk("par_reads", par_log.size(), 4);
    chk("lcu1_first_addr", lcu1_addr, 64);

    // Size 32 with periodic 5-cycle busy bursts.
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom_range(255));
    for (int p = 0; p < 64; p++) pmem[p] = 24'($urandom);
    begin_frame(2'd1, 1);
    finish_frame();

    // Reset in the middle of a frame.
    begin_frame(2'd0, 0);
    wait_idx(5000);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    chk("abort_no_done", done_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    // Restart with random 30% busy, size 16.
    begin_frame(2'd0, 2);
    finish_frame();
    chk("restart_first_addr", first_rd_addr, 0);

    checking = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
